// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing package: 640x480@60 default constants, counter widths and helpers.
// Imported by vga_sync_gen and by the downstream graphics that compares coordinates.
package vga_sync_gen_pkg;

  localparam int unsigned DEF_CLK_DIV   = 2;
  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned CNT_W   = 10;
  // Divider count range is 0..CLK_DIV-1 with CLK_DIV up to 16.
  localparam int unsigned DIV_W   = 4;
  localparam int unsigned FRAME_W = 16;

  typedef logic [CNT_W-1:0] coord_t;

  function automatic logic in_range(input int unsigned v, input int unsigned lo,
                                    input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_mod_counter.sv
// vga_mod_counter: enabled mod-N counter; wrap is high in the enabled cycle that returns to 0.
module vga_mod_counter #(
  parameter int unsigned N = 800,
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q, count_d;

  assign wrap  = en && (count_q == W'(N - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (en) count_d = wrap ? '0 : count_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing from the system clock (pixel divider, h/v counters, sync/blank flags).
// Defining VGA_FRAME_CNT_EN adds the frame_count output.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 p_tick,
  output logic [CNT_W-1:0]     pixel_x,
  output logic [CNT_W-1:0]     pixel_y,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 video_on,
`ifdef VGA_FRAME_CNT_EN
  output logic [FRAME_W-1:0]   frame_count,
`endif
  output logic                 frame_tick
);

  localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_en;
  logic             p_tick_q, p_tick_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             frame_tick_q, frame_tick_d;
  coord_t           x_cnt, y_cnt, x_nxt, y_nxt;
  logic             h_wrap, v_wrap;

  // Counters and flags all step on the same edge that raises p_tick, so they stay coherent.
  assign pix_en = (div_cnt_q == DIV_W'(CLK_DIV - 1));

  vga_mod_counter #(.N(H_TOTAL), .W(CNT_W)) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .count (x_cnt),
    .wrap  (h_wrap)
  );

  vga_mod_counter #(.N(V_TOTAL), .W(CNT_W)) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en & h_wrap),
    .count (y_cnt),
    .wrap  (v_wrap)
  );

  always_comb begin
    div_cnt_d    = pix_en ? '0 : div_cnt_q + DIV_W'(1);
    p_tick_d     = pix_en;
    x_nxt        = x_cnt;
    y_nxt        = y_cnt;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    video_on_d   = video_on_q;
    frame_tick_d = 1'b0;
    if (pix_en) begin
      x_nxt        = h_wrap ? '0 : x_cnt + CNT_W'(1);
      if (h_wrap) y_nxt = v_wrap ? '0 : y_cnt + CNT_W'(1);
      hsync_d      = !in_range(32'(x_nxt), H_SYNC_START, H_SYNC_END);
      vsync_d      = !in_range(32'(y_nxt), V_SYNC_START, V_SYNC_END);
      video_on_d   = (32'(x_nxt) < H_DISPLAY) && (32'(y_nxt) < V_DISPLAY);
      frame_tick_d = (x_nxt == '0) && (y_nxt == CNT_W'(V_DISPLAY));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q    <= '0;
      p_tick_q     <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      p_tick_q     <= p_tick_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      frame_tick_q <= frame_tick_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_tick_d ? frame_cnt_q + FRAME_W'(1) : frame_cnt_q;
  assign frame_count = frame_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end
`endif

  assign p_tick     = p_tick_q;
  assign pixel_x    = x_cnt;
  assign pixel_y    = y_cnt;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign frame_tick = frame_tick_q;

endmodule
